riscv_mem_arbiter: RTL and testbench

Single-port memory arbiter for the RV32 core. It shares one synchronous memory between three requesters: the debug read port, the load/store unit (LSU) and the instruction fetch unit (IFU). Priority is fixed, with a starvation counter so fetch is never locked out by back-to-back data accesses. It can issue one memory access per cycle and routes each 1-cycle-latency response back to the port that owns it.

---
 rtl/riscv_mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_riscv_mem_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mem_arbiter.sv
// Single-port memory arbiter for the RV32 core: debug > LSU > IFU, with a
// starvation override that lets a repeatedly denied fetch win over the LSU.
package riscv_pkg;
    parameter int XLEN = 32;
endpackage

module riscv_mem_arbiter #(
    parameter int XLEN       = riscv_pkg::XLEN,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk_i,
    input  logic            rstn_i,

    input  logic            dbg_req_i,
    input  logic            dbg_we_i,
    input  logic [XLEN-1:0] dbg_addr_i,
    input  logic [XLEN-1:0] dbg_wdata_i,
    input  logic [3:0]      dbg_be_i,
    output logic            dbg_gnt_o,
    output logic            dbg_rvalid_o,
    output logic [XLEN-1:0] dbg_rdata_o,

    input  logic            lsu_req_i,
    input  logic            lsu_we_i,
    input  logic [XLEN-1:0] lsu_addr_i,
    input  logic [XLEN-1:0] lsu_wdata_i,
    input  logic [3:0]      lsu_be_i,
    output logic            lsu_gnt_o,
    output logic            lsu_rvalid_o,
    output logic [XLEN-1:0] lsu_rdata_o,

    input  logic            ifu_req_i,
    input  logic            ifu_we_i,
    input  logic [XLEN-1:0] ifu_addr_i,
    input  logic [XLEN-1:0] ifu_wdata_i,
    input  logic [3:0]      ifu_be_i,
    output logic            ifu_gnt_o,
    output logic            ifu_rvalid_o,
    output logic [XLEN-1:0] ifu_rdata_o,

    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic [3:0]      mem_be_o,
    input  logic [XLEN-1:0] mem_rdata_i
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DBG  = 2'd1,
        OWN_LSU  = 2'd2,
        OWN_IFU  = 2'd3
    } owner_e;

    owner_e     owner_d, owner_q;
    logic [3:0] starve_d, starve_q;
    logic       ifu_starved_s;

    assign ifu_starved_s = (starve_q == STARVE_LIM);

    // Winner selection; nothing is granted while reset is held
    always_comb begin
        owner_d = OWN_NONE;
        if (!rstn_i) begin
            owner_d = OWN_NONE;
        end else if (dbg_req_i) begin
            owner_d = OWN_DBG;
        end else if (ifu_req_i && ifu_starved_s) begin
            owner_d = OWN_IFU;
        end else if (lsu_req_i) begin
            owner_d = OWN_LSU;
        end else if (ifu_req_i) begin
            owner_d = OWN_IFU;
        end else begin
            owner_d = OWN_NONE;
        end
    end

    assign dbg_gnt_o = (owner_d == OWN_DBG);
    assign lsu_gnt_o = (owner_d == OWN_LSU);
    assign ifu_gnt_o = (owner_d == OWN_IFU);
    assign mem_req_o = (owner_d != OWN_NONE);

    // Memory-side request fields follow the winner, zero when idle
    always_comb begin
        mem_we_o    = 1'b0;
        mem_addr_o  = {XLEN{1'b0}};
        mem_wdata_o = {XLEN{1'b0}};
        mem_be_o    = 4'b0000;
        case (owner_d)
            OWN_DBG: begin
                mem_we_o    = dbg_we_i;
                mem_addr_o  = dbg_addr_i;
                mem_wdata_o = dbg_wdata_i;
                mem_be_o    = dbg_be_i;
            end
            OWN_LSU: begin
                mem_we_o    = lsu_we_i;
                mem_addr_o  = lsu_addr_i;
                mem_wdata_o = lsu_wdata_i;
                mem_be_o    = lsu_be_i;
            end
            OWN_IFU: begin
                mem_we_o    = ifu_we_i;
                mem_addr_o  = ifu_addr_i;
                mem_wdata_o = ifu_wdata_i;
                mem_be_o    = ifu_be_i;
            end
            default: begin
                mem_we_o    = 1'b0;
                mem_addr_o  = {XLEN{1'b0}};
                mem_wdata_o = {XLEN{1'b0}};
                mem_be_o    = 4'b0000;
            end
        endcase
    end

    // Denied fetch cycles, saturating; debug wins do not reset the count
    always_comb begin
        starve_d = 4'd0;
        if (ifu_req_i && !ifu_gnt_o) begin
            starve_d = (starve_q < STARVE_LIM) ? (starve_q + 4'd1) : STARVE_LIM;
        end else begin
            starve_d = 4'd0;
        end
    end

    // Owner and starvation state
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            owner_q  <= OWN_NONE;
            starve_q <= 4'd0;
        end else begin
            owner_q  <= owner_d;
            starve_q <= starve_d;
        end
    end

    // A response in flight when reset arrives is dropped, not reported
    assign dbg_rvalid_o = rstn_i && (owner_q == OWN_DBG);
    assign lsu_rvalid_o = rstn_i && (owner_q == OWN_LSU);
    assign ifu_rvalid_o = rstn_i && (owner_q == OWN_IFU);

    assign dbg_rdata_o = mem_rdata_i;
    assign lsu_rdata_o = mem_rdata_i;
    assign ifu_rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Self-checking bench for riscv_mem_arbiter: vector table, directed corner
// sequences and a randomized run against an abstract arbitration model.
module tb_riscv_mem_arbiter;

    localparam int XLEN   = 32;
    localparam int STARVE = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic [2:0]  req_v;
    logic [2:0]  we_v;
    logic [31:0] addr_v  [3];
    logic [31:0] wdata_v [3];
    logic [3:0]  be_v    [3];

    logic        dbg_gnt, lsu_gnt, ifu_gnt;
    logic        dbg_rv, lsu_rv, ifu_rv;
    logic [31:0] rd [3];
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;

    logic [2:0] gnt_vec, rv_vec;
    assign gnt_vec = {dbg_gnt, lsu_gnt, ifu_gnt};
    assign rv_vec  = {dbg_rv, lsu_rv, ifu_rv};

    riscv_mem_arbiter #(.XLEN(XLEN), .STARVE_MAX(STARVE)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .dbg_req_i(req_v[2]), .dbg_we_i(we_v[2]), .dbg_addr_i(addr_v[2]),
        .dbg_wdata_i(wdata_v[2]), .dbg_be_i(be_v[2]), .dbg_gnt_o(dbg_gnt),
        .dbg_rvalid_o(dbg_rv), .dbg_rdata_o(rd[2]),
        .lsu_req_i(req_v[1]), .lsu_we_i(we_v[1]), .lsu_addr_i(addr_v[1]),
        .lsu_wdata_i(wdata_v[1]), .lsu_be_i(be_v[1]), .lsu_gnt_o(lsu_gnt),
        .lsu_rvalid_o(lsu_rv), .lsu_rdata_o(rd[1]),
        .ifu_req_i(req_v[0]), .ifu_we_i(we_v[0]), .ifu_addr_i(addr_v[0]),
        .ifu_wdata_i(wdata_v[0]), .ifu_be_i(be_v[0]), .ifu_gnt_o(ifu_gnt),
        .ifu_rvalid_o(ifu_rv), .ifu_rdata_o(rd[0]),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rdata_i(mem_rdata)
    );

    // Behavioural memory: small writable window at 0x8000_00xx, pattern elsewhere
    logic [31:0] wmem [16];
    logic [15:0] wvld;

    function automatic logic [31:0] mem_pattern(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16]};
    endfunction

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (a[31:8] == 24'h800000 && wvld[a[5:2]]) return wmem[a[5:2]];
        if (a == 32'h8000_0000) return 32'h0000_0297;
        return mem_pattern(a);
    endfunction

    initial wvld = 16'h0000;

    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) begin
                if (mem_addr[31:8] == 24'h800000) begin
                    wmem[mem_addr[5:2]] <= mem_wdata;
                    wvld[mem_addr[5:2]] <= 1'b1;
                end
            end else begin
                mem_rdata <= mem_read(mem_addr);
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       rstn;
        logic [2:0] req;
        logic [2:0] gnt;
        logic [2:0] rv;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [2:0] onehot(input int w);
        logic [2:0] v;
        v = 3'b000;
        if (w >= 0) v[w] = 1'b1;
        return v;
    endfunction

    int          denied, prev_w, w;
    logic [31:0] prev_addr, exp_addr;
    logic [2:0]  exp_g, exp_rv;
    bit          pend [3];

    initial begin
        rstn  = 1'b0;
        req_v = 3'b000;
        we_v  = 3'b000;
        for (int i = 0; i < 3; i++) begin
            addr_v[i]  = 32'h4000_0000 + 32'(i * 16);
            wdata_v[i] = 32'h1111_0000 + 32'(i);
            be_v[i]    = 4'b1111;
        end

        // {rstn, req{dbg,lsu,ifu}, expected gnt, expected rvalid}
        repeat (3) tbl.push_back('{1'b0, 3'b111, 3'b000, 3'b000});
        tbl.push_back('{1'b1, 3'b111, 3'b100, 3'b000});
        repeat (5) tbl.push_back('{1'b1, 3'b111, 3'b100, 3'b100});
        tbl.push_back('{1'b1, 3'b011, 3'b001, 3'b100});
        repeat (2) begin
            tbl.push_back('{1'b1, 3'b011, 3'b010, 3'b001});
            repeat (3) tbl.push_back('{1'b1, 3'b011, 3'b010, 3'b010});
            tbl.push_back('{1'b1, 3'b011, 3'b001, 3'b010});
        end
        tbl.push_back('{1'b1, 3'b000, 3'b000, 3'b001});
        tbl.push_back('{1'b1, 3'b000, 3'b000, 3'b000});
        tbl.push_back('{1'b1, 3'b001, 3'b001, 3'b000});
        tbl.push_back('{1'b1, 3'b100, 3'b100, 3'b001});
        tbl.push_back('{1'b1, 3'b010, 3'b010, 3'b100});
        tbl.push_back('{1'b1, 3'b000, 3'b000, 3'b010});

        @(posedge clk); #1;
        foreach (tbl[k]) begin
            rstn  = tbl[k].rstn;
            req_v = tbl[k].req;
            @(negedge clk);
            check($sformatf("tbl%0d_gnt", k), {29'd0, gnt_vec}, {29'd0, tbl[k].gnt});
            check($sformatf("tbl%0d_rvalid", k), {29'd0, rv_vec}, {29'd0, tbl[k].rv});
            check($sformatf("tbl%0d_mem_req", k), {31'd0, mem_req}, {31'd0, |tbl[k].gnt});
            exp_addr = 32'h0;
            for (int i = 0; i < 3; i++) if (tbl[k].gnt[i]) exp_addr = addr_v[i];
            check($sformatf("tbl%0d_mem_addr", k), mem_addr, exp_addr);
            @(posedge clk); #1;
        end

        // Single IFU read
        addr_v[0] = 32'h8000_0000; req_v = 3'b001;
        @(negedge clk);
        check("ifu_rd_gnt", {29'd0, gnt_vec}, 32'd1);
        check("ifu_rd_addr", mem_addr, 32'h8000_0000);
        check("ifu_rd_we", {31'd0, mem_we}, 32'd0);
        @(posedge clk); #1;
        req_v = 3'b000;
        @(negedge clk);
        check("ifu_rd_rvalid", {29'd0, rv_vec}, 32'd1);
        check("ifu_rd_rdata", rd[0], 32'h0000_0297);
        @(posedge clk); #1;

        // LSU write then read-back
        addr_v[1] = 32'h8000_0010; wdata_v[1] = 32'hDEAD_BEEF; be_v[1] = 4'b1111;
        we_v = 3'b010; req_v = 3'b010;
        @(negedge clk);
        check("lsu_wr_gnt", {29'd0, gnt_vec}, 32'd2);
        check("lsu_wr_we", {31'd0, mem_we}, 32'd1);
        check("lsu_wr_addr", mem_addr, 32'h8000_0010);
        check("lsu_wr_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("lsu_wr_be", {28'd0, mem_be}, 32'hF);
        @(posedge clk); #1;
        we_v = 3'b000; req_v = 3'b010;
        @(negedge clk);
        check("lsu_wr_ack", {29'd0, rv_vec}, 32'd2);
        @(posedge clk); #1;
        req_v = 3'b000;
        @(negedge clk);
        check("lsu_rb_rvalid", {29'd0, rv_vec}, 32'd2);
        check("lsu_rb_rdata", rd[1], 32'hDEAD_BEEF);
        @(posedge clk); #1;

        // Reset arriving while an LSU response is pending
        addr_v[1] = 32'h8000_0020; req_v = 3'b010;
        @(negedge clk);
        check("rst_mid_gnt", {29'd0, gnt_vec}, 32'd2);
        @(posedge clk); #1;
        rstn = 1'b0; req_v = 3'b000;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check($sformatf("rst_mid_rv%0d", c), {29'd0, rv_vec}, 32'd0);
            @(posedge clk); #1;
        end
        rstn = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check($sformatf("rst_rel_rv%0d", c), {29'd0, rv_vec}, 32'd0);
            @(posedge clk); #1;
        end

        // Randomized run: model tracks pending requests and the denied-fetch run
        denied = 0; prev_w = -1; prev_addr = 32'h0;
        for (int i = 0; i < 3; i++) pend[i] = 1'b0;
        we_v = 3'b000;
        for (int cyc = 0; cyc < 400; cyc++) begin
            rstn = (cyc == 0) ? 1'b0 : ($urandom_range(0, 39) != 0);
            for (int i = 0; i < 3; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i]    = 1'b1;
                    addr_v[i]  = 32'h1000_0000 | ($urandom & 32'h0000_FFFC);
                    wdata_v[i] = $urandom;
                    be_v[i]    = 4'($urandom);
                end
            end
            req_v = {pend[2], pend[1], pend[0]};
            w = -1;
            if (rstn) begin
                if (pend[2])                        w = 2;
                else if (pend[0] && denied >= STARVE) w = 0;
                else if (pend[1])                   w = 1;
                else if (pend[0])                   w = 0;
            end
            exp_g  = onehot(w);
            exp_rv = rstn ? onehot(prev_w) : 3'b000;
            @(negedge clk);
            check("rnd_gnt", {29'd0, gnt_vec}, {29'd0, exp_g});
            check("rnd_rvalid", {29'd0, rv_vec}, {29'd0, exp_rv});
            check("rnd_mem_addr", mem_addr, (w < 0) ? 32'h0 : addr_v[w]);
            if (exp_rv != 3'b000) check("rnd_rdata", rd[prev_w], mem_pattern(prev_addr));
            if (rstn && pend[0] && w != 0) denied++;
            else denied = 0;
            prev_w = w;
            if (w >= 0) begin
                prev_addr = addr_v[w];
                pend[w]   = 1'b0;
            end
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
